// File: rtl/yarvi_lsu_pkg.sv
// Shared types for the yarvi load/store unit: access size codes, timer register
// selects and the lane alignment helpers used on both the store and load paths.
package yarvi_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_BAD = 2'd3} size_e;

    // Word index within the 16-byte timer window (req_addr[3:2]).
    typedef enum logic [1:0] {
        MTIME_LO    = 2'd0,
        MTIME_HI    = 2'd1,
        MTIMECMP_LO = 2'd2,
        MTIMECMP_HI = 2'd3
    } io_reg_e;

    function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] a);
        logic [3:0] m;
        case (sz)
            SZ_B:    m = 4'b0001 << a;
            SZ_H:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_replicate(input size_e sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] a,
                                                input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {a, 3'b000};
        case (f3[1:0])
            2'd0:    r = f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    r = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/yarvi_lsu_if.sv
// EX -> LSU request and LSU -> WB response bundle.
// Handshake: req_valid qualifies all req_* in the cycle it is high and is always
// accepted (no ready); rsp_* describe that request exactly one cycle later.
interface yarvi_lsu_if;
    logic        req_valid;
    logic [31:0] req_pc;
    logic [4:0]  req_rd;
    logic [31:0] req_addr;
    logic        req_re;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_pc;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_val;
    logic        rsp_exc_misaligned;
    logic        rsp_exc_access;
    logic [31:0] rsp_exc_mtval;
    logic        rsp_load_hit_store;

    modport master (
        output req_valid, req_pc, req_rd, req_addr, req_re, req_we, req_funct3, req_wdata,
        input  rsp_valid, rsp_pc, rsp_rd, rsp_val, rsp_exc_misaligned, rsp_exc_access,
               rsp_exc_mtval, rsp_load_hit_store
    );

    modport slave (
        input  req_valid, req_pc, req_rd, req_addr, req_re, req_we, req_funct3, req_wdata,
        output rsp_valid, rsp_pc, rsp_rd, rsp_val, rsp_exc_misaligned, rsp_exc_access,
               rsp_exc_mtval, rsp_load_hit_store
    );
endinterface

// File: rtl/yarvi_lsu_timer.sv
// Memory-mapped machine timer: prescaler, 64-bit mtime/mtimecmp, registered
// compare interrupt and the combinational IO read mux.
module yarvi_lsu_timer import yarvi_lsu_pkg::*; #(
    parameter int TIMER_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_we,
    input  io_reg_e     io_sel,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        timer_interrupt
);
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   mtime, mtime_d;
    logic [63:0]   mtimecmp, mtimecmp_d;

    assign tick = (presc == PW'(TIMER_DIV - 1));

    // A software write to either mtime half overrides that cycle's increment.
    always_comb begin
        mtime_d    = tick ? mtime + 64'd1 : mtime;
        mtimecmp_d = mtimecmp;
        if (io_we) begin
            case (io_sel)
                MTIME_LO:    mtime_d    = {mtime[63:32], io_wdata};
                MTIME_HI:    mtime_d    = {io_wdata, mtime[31:0]};
                MTIMECMP_LO: mtimecmp_d = {mtimecmp[63:32], io_wdata};
                MTIMECMP_HI: mtimecmp_d = {io_wdata, mtimecmp[31:0]};
            endcase
        end
    end

    always_comb begin
        case (io_sel)
            MTIME_LO:    io_rdata = mtime[31:0];
            MTIME_HI:    io_rdata = mtime[63:32];
            MTIMECMP_LO: io_rdata = mtimecmp[31:0];
            MTIMECMP_HI: io_rdata = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc           <= '0;
            mtime           <= '0;
            mtimecmp        <= '1;
            timer_interrupt <= 1'b0;
        end else begin
            presc           <= tick ? '0 : presc + 1'b1;
            mtime           <= mtime_d;
            mtimecmp        <= mtimecmp_d;
            timer_interrupt <= (mtime >= mtimecmp);
        end
    end
endmodule

// File: rtl/yarvi_lsu.sv
// yarvi load/store unit: decode and fault checks, four byte-lane RAMs behind a
// one-entry pending-write register, timer IO and the 1-cycle response stage.
module yarvi_lsu import yarvi_lsu_pkg::*; #(
    parameter int          PMSB      = 13,
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] IO_BASE   = 32'h4000_0000,
    parameter int          TIMER_DIV = 1,
    parameter bit          FWD       = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    yarvi_lsu_if.slave  lsu,
    output logic        timer_interrupt,
    output logic [31:0] code_address,
    output logic [31:0] code_writedata,
    output logic [3:0]  code_writemask
);
    localparam int WW        = PMSB - 1;
    localparam int RAM_WORDS = 1 << WW;

    size_e       size;
    logic        mem_op, misaligned, in_ram, in_io, access_fault;
    logic        ram_store, io_store, ram_load, word_hit, hit_stall, accept;
    logic [WW-1:0] req_word, pend_word;
    logic [31:0] io_rdata, ram_q, merged;

    logic        ram_load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  fwd_mask_q;
    logic [31:0] fwd_data_q, val_q;

    assign size      = size_e'(lsu.req_funct3[1:0]);
    assign req_word  = lsu.req_addr[PMSB:2];
    assign pend_word = code_address[PMSB:2];
    assign mem_op    = lsu.req_valid && (lsu.req_re || lsu.req_we);
    assign in_ram    = (lsu.req_addr[31:PMSB+1] == MEM_BASE[31:PMSB+1]);
    assign in_io     = (lsu.req_addr[31:4] == IO_BASE[31:4]);

    assign misaligned = mem_op && (size == SZ_BAD ||
                                   (size == SZ_H && lsu.req_addr[0]) ||
                                   (size == SZ_W && lsu.req_addr[1:0] != 2'b00));
    assign access_fault = mem_op && !misaligned &&
                          (!(in_ram || in_io) || (in_io && lsu.req_funct3 != F3_W));

    assign ram_store = mem_op && lsu.req_we && !misaligned && !access_fault && in_ram;
    assign io_store  = mem_op && lsu.req_we && !misaligned && !access_fault && in_io;
    assign ram_load  = mem_op && lsu.req_re && !misaligned && !access_fault && in_ram;

    // The pending entry is live exactly when its mask is non-zero.
    assign word_hit  = ram_load && (code_writemask != 4'b0000) && (pend_word == req_word);
    assign hit_stall = !FWD && word_hit;
    assign accept    = lsu.req_valid && !misaligned && !access_fault && !hit_stall;

    yarvi_lsu_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
        .clock           (clock),
        .reset           (reset),
        .io_we           (io_store),
        .io_sel          (io_reg_e'(lsu.req_addr[3:2])),
        .io_wdata        (lsu.req_wdata),
        .io_rdata        (io_rdata),
        .timer_interrupt (timer_interrupt)
    );

    // Read-before-write: a load in the commit cycle sees old RAM data, hence the merge below.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [RAM_WORDS];
        logic [7:0] q;
        always_ff @(posedge clock) begin
            if (!reset && code_writemask[l]) mem[pend_word] <= code_writedata[8*l +: 8];
            if (lsu.req_valid && lsu.req_re) q <= mem[req_word];
        end
        assign ram_q[8*l +: 8] = q;
    end

    always_comb begin
        merged = ram_q;
        for (int l = 0; l < 4; l++) begin
            if (fwd_mask_q[l]) merged[8*l +: 8] = fwd_data_q[8*l +: 8];
        end
    end

    assign lsu.rsp_val = ram_load_q ? load_extend(merged, addr_lo_q, funct3_q) : val_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lsu.rsp_valid          <= 1'b0;
            lsu.rsp_pc             <= '0;
            lsu.rsp_rd             <= '0;
            lsu.rsp_exc_misaligned <= 1'b0;
            lsu.rsp_exc_access     <= 1'b0;
            lsu.rsp_exc_mtval      <= '0;
            lsu.rsp_load_hit_store <= 1'b0;
            code_address           <= '0;
            code_writedata         <= '0;
            code_writemask         <= '0;
            ram_load_q             <= 1'b0;
            funct3_q               <= '0;
            addr_lo_q              <= '0;
            fwd_mask_q             <= '0;
            fwd_data_q             <= '0;
            val_q                  <= '0;
        end else begin
            lsu.rsp_valid          <= accept;
            lsu.rsp_pc             <= lsu.req_pc;
            lsu.rsp_rd             <= accept ? lsu.req_rd : 5'd0;
            lsu.rsp_exc_misaligned <= misaligned;
            lsu.rsp_exc_access     <= access_fault;
            lsu.rsp_exc_mtval      <= lsu.req_addr;
            lsu.rsp_load_hit_store <= hit_stall;
            code_writemask         <= ram_store ? byte_mask(size, lsu.req_addr[1:0]) : 4'b0000;
            if (ram_store) begin
                code_address   <= lsu.req_addr;
                code_writedata <= lane_replicate(size, lsu.req_wdata);
            end
            ram_load_q <= ram_load && !hit_stall;
            funct3_q   <= lsu.req_funct3;
            addr_lo_q  <= lsu.req_addr[1:0];
            fwd_mask_q <= (FWD && word_hit) ? code_writemask : 4'b0000;
            fwd_data_q <= code_writedata;
            val_q      <= (ram_load || !(lsu.req_re && in_io && !misaligned && !access_fault))
                          ? lsu.req_addr : io_rdata;
        end
    end
endmodule
